// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - VGA raster generator with pipeline-aligned sync/blank and DAC output register.
module vga_scan_driver #(
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pix_en,
    output logic       frame_start,
    output logic       frame_clk,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = $clog2(CLK_DIV);

    // {hs, vs, blank_n} as seen while the pins are idle
    localparam logic [2:0] IDLE = 3'b110;

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;
    logic [9:0]    hc;
    logic [9:0]    vc;
    logic          h_end;
    logic          v_end;
    logic          hs_raw;
    logic          vs_raw;
    logic          blank_raw_n;
    logic [2:0]    raw;
    logic [2:0]    tail;

    assign div_next = (div == DW'(CLK_DIV - 1)) ? '0 : div + 1'b1;

    // pix_en and VGA_CLK are decoded from the next divider value so they line up with div
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div     <= '0;
            pix_en  <= 1'b0;
            VGA_CLK <= 1'b0;
        end else begin
            div     <= div_next;
            pix_en  <= (div_next == DW'(CLK_DIV - 1));
            VGA_CLK <= (div_next >= DW'(CLK_DIV / 2));
        end
    end

    assign h_end = (hc == 10'(H_TOTAL - 1));
    assign v_end = (vc == 10'(V_TOTAL - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hc          <= '0;
            vc          <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_end && v_end;
            if (pix_en) begin
                hc <= h_end ? '0 : hc + 1'b1;
                if (h_end) begin
                    vc <= v_end ? '0 : vc + 1'b1;
                end
            end
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;

    assign hs_raw      = !((hc >= 10'(H_VISIBLE + H_FRONT)) && (hc < 10'(H_VISIBLE + H_FRONT + H_SYNC)));
    assign vs_raw      = !((vc >= 10'(V_VISIBLE + V_FRONT)) && (vc < 10'(V_VISIBLE + V_FRONT + V_SYNC)));
    assign blank_raw_n = (hc < 10'(H_VISIBLE)) && (vc < 10'(V_VISIBLE));
    assign raw         = {hs_raw, vs_raw, blank_raw_n};

    // Delay line matches the colour path latency of the sprite memory reads
    generate
        if (PIPE_DELAY == 0) begin : g_nopipe
            assign tail = raw;
        end else begin : g_pipe
            logic [2:0] stage [PIPE_DELAY];

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        stage[i] <= IDLE;
                    end
                end else if (pix_en) begin
                    stage[0] <= raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign tail = stage[PIPE_DELAY-1];
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_en) begin
            VGA_HS      <= tail[2];
            VGA_VS      <= tail[1];
            VGA_BLANK_N <= tail[0];
            VGA_R       <= tail[0] ? Red_in   : 8'd0;
            VGA_G       <= tail[0] ? Green_in : 8'd0;
            VGA_B       <= tail[0] ? Blue_in  : 8'd0;
        end
    end

    assign frame_clk  = VGA_VS;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scan_driver.sv
// tb/tb_vga_scan_driver.sv - directed checks of vga_scan_driver at default and reduced timings.
module tb_vga_scan_driver;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       rst_a, rst_b;
    logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic       pe_a, fs_a, fc_a, vclk_a, hs_a, vs_a, bn_a, sn_a;
    logic       pe_b, fs_b, fc_b, vclk_b, hs_b, vs_b, bn_b, sn_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;

    int total = 0;
    int bad   = 0;

    vga_scan_driver #(.PIPE_DELAY(1)) dut_a (
        .Clk(Clk), .Reset(rst_a), .Red_in(red_a), .Green_in(green_a), .Blue_in(blue_a),
        .DrawX(x_a), .DrawY(y_a), .pix_en(pe_a), .frame_start(fs_a), .frame_clk(fc_a),
        .VGA_CLK(vclk_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sn_a),
        .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
    );

    vga_scan_driver #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIPE_DELAY(2)
    ) dut_b (
        .Clk(Clk), .Reset(rst_b), .Red_in(red_b), .Green_in(green_b), .Blue_in(blue_b),
        .DrawX(x_b), .DrawY(y_b), .pix_en(pe_b), .frame_start(fs_b), .frame_clk(fc_b),
        .VGA_CLK(vclk_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sn_b),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        int t, p, hp, vp;
        int hs_low, first_low, ff_cnt, bn_cnt;
        int fs_cnt, fs_first, fs_second, vs_low, rises, xmax, ymax;
        logic ehs, evs, ebn, prev_fc;
        logic [7:0] d1, d2;

        rst_a = 1'b1; rst_b = 1'b1;
        red_a = 8'hFF; green_a = 8'h5A; blue_a = 8'hC3;
        red_b = 8'h00; green_b = 8'h11; blue_b = 8'h00;
        repeat (3) @(negedge Clk);

        chk("rst_drawx", x_a, 0);      chk("rst_drawy", y_a, 0);
        chk("rst_pix_en", pe_a, 0);    chk("rst_frame_start", fs_a, 0);
        chk("rst_hs", hs_a, 1);        chk("rst_vs", vs_a, 1);
        chk("rst_frame_clk", fc_a, 1); chk("rst_blank_n", bn_a, 0);
        chk("rst_rgb", {r_a, g_a, b_a}, 0);
        chk("rst_vga_clk", vclk_a, 0); chk("rst_sync_n", sn_a, 0);

        // Default timing: first line after release
        @(negedge Clk);
        rst_a = 1'b0;
        hs_low = 0; first_low = -1; ff_cnt = 0; bn_cnt = 0;
        for (int c = 0; c < 1600; c++) begin
            if (c > 0) @(negedge Clk);
            t = c / 2;
            chk("a_pix_en", pe_a, c % 2);
            chk("a_vga_clk", vclk_a, c % 2);
            chk("a_drawx", x_a, t);
            chk("a_drawy", y_a, 0);
            if (c % 2 == 1) begin
                p   = t - 2;
                ehs = !(p >= 656 && p < 752);
                ebn = (p >= 0 && p < 640);
                chk("a_hs", hs_a, ehs);
                chk("a_blank_n", bn_a, ebn);
                chk("a_red", r_a, ebn ? 8'hFF : 8'h00);
                if (t == 100) chk("a_green_blue", {g_a, b_a}, 16'h5AC3);
                if (!hs_a) begin
                    hs_low++;
                    if (first_low < 0) first_low = t;
                end
                if (r_a == 8'hFF) ff_cnt++;
                if (bn_a) bn_cnt++;
            end
        end
        chk("a_hs_width", hs_low, 96);
        chk("a_hs_fall_tick", first_low, 658);
        chk("a_red_ff_ticks", ff_cnt, 640);
        chk("a_blank_n_ticks", bn_cnt, 640);
        chk("a_sync_n", sn_a, 0);

        // Mid-line asynchronous reset at hc=300, vc=1
        for (int c = 1600; c <= 2200; c++) @(negedge Clk);
        chk("a_pre_rst_drawx", x_a, 300);
        chk("a_pre_rst_drawy", y_a, 1);
        rst_a = 1'b1;
        #1;
        chk("a_mid_rst_drawx", x_a, 0);  chk("a_mid_rst_drawy", y_a, 0);
        chk("a_mid_rst_hs", hs_a, 1);    chk("a_mid_rst_blank_n", bn_a, 0);
        chk("a_mid_rst_red", r_a, 0);    chk("a_mid_rst_pix_en", pe_a, 0);
        repeat (2) @(negedge Clk);
        rst_a = 1'b0;
        repeat (4) @(negedge Clk);
        chk("a_restart_drawx", x_a, 2);
        chk("a_restart_drawy", y_a, 0);

        // Reduced timing, PIPE_DELAY=2, ROM returns DrawX[7:0] two ticks later
        @(negedge Clk);
        rst_b = 1'b0;
        d1 = 0; d2 = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
        vs_low = 0; hs_low = 0; rises = 0; prev_fc = 1'b1; xmax = 0; ymax = 0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge Clk);
            t = c / 2;
            chk("b_drawx", x_b, t % 12);
            chk("b_drawy", y_b, (t / 12) % 7);
            if (int'(x_b) > xmax) xmax = int'(x_b);
            if (int'(y_b) > ymax) ymax = int'(y_b);
            if (fs_b) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
            end
            if (c % 2 == 1) begin
                red_b = d2;
                d2 = d1;
                d1 = x_b[7:0];
                p = t - 3;
                if (p < 0) begin
                    ehs = 1'b1; evs = 1'b1; ebn = 1'b0; hp = 0;
                end else begin
                    hp  = p % 12;
                    vp  = (p / 12) % 7;
                    ehs = !(hp >= 9 && hp < 11);
                    evs = (vp != 5);
                    ebn = (hp < 8 && vp < 4);
                end
                chk("b_hs", hs_b, ehs);
                chk("b_vs", vs_b, evs);
                chk("b_blank_n", bn_b, ebn);
                chk("b_red_align", r_b, ebn ? hp : 0);
                chk("b_green", g_b, ebn ? 8'h11 : 8'h00);
                if (!hs_b) hs_low++;
                if (!vs_b) vs_low++;
                if (fc_b && !prev_fc) rises++;
                prev_fc = fc_b;
            end
        end
        chk("b_drawx_max", xmax, 11);
        chk("b_drawy_max", ymax, 6);
        chk("b_frame_starts", fs_cnt, 3);
        chk("b_first_frame_start", fs_first, 168);
        chk("b_frame_period", fs_second - fs_first, 168);
        chk("b_hs_low_ticks", hs_low, 48);
        chk("b_vs_low_ticks", vs_low, 36);
        chk("b_frame_clk_rises", rises, 3);

        // Mid-frame reset on the reduced raster, then frame_start at the next wrap
        repeat (11) @(negedge Clk);
        chk("b_pre_rst_drawx", x_b, 5);
        chk("b_pre_rst_drawy", y_b, 4);
        rst_b = 1'b1;
        #1;
        chk("b_mid_rst_pos", {x_b, y_b}, 0);
        chk("b_mid_rst_pins", {hs_b, vs_b, bn_b, r_b, g_b}, {3'b110, 16'h0});
        @(negedge Clk);
        rst_b = 1'b0;
        fs_first = -1;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge Clk);
            if (fs_b && fs_first < 0) fs_first = c;
        end
        chk("b_restart_frame_start", fs_first, 168);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
